// File: rtl/pcle_pkg.sv
// Shared types and constants for the pcle loadable counter sequencer.
package pcle_pkg;

    localparam int PCLE_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

endpackage

// File: rtl/pcle_next.sv
// Combinational next-count datapath: load mux, increment and wrap detection.
module pcle_next
    import pcle_pkg::*;
#(
    parameter int WIDTH = PCLE_WIDTH
) (
    input  logic [WIDTH-1:0] count,
    input  logic [WIDTH-1:0] ld_data,
    input  logic             load,
    input  logic             inc,
    output logic [WIDTH-1:0] next_count,
    output logic             wrap
);

    // NOTE: every output gets a default first so no path through the block can infer a latch.
    always_comb begin
        next_count = count;
        wrap       = 1'b0;
        if (load) begin
            next_count = ld_data;
        end else if (inc) begin
            next_count = count + 1'b1;
            wrap       = &count;
        end
    end

endmodule

// File: rtl/pcle_seq.sv
// Loadable up-counter with IDLE/RUN/HALT sequencing, terminal-count halt and
// registered carry/done pulses.
module pcle_seq
    import pcle_pkg::*;
#(
    parameter int WIDTH   = PCLE_WIDTH,
    parameter bit TC_HALT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             ld_valid,
    output logic             ld_ready,
    input  logic [WIDTH-1:0] ld_data,
    input  logic             start,
    input  logic             cnt_en,
    output logic [WIDTH-1:0] count,
    output logic             carry,
    output logic             busy,
    output logic             done
);

    state_t           state, state_next;
    logic             load, inc, wrap;
    logic [WIDTH-1:0] next_count;

    // ld_ready and busy depend on state only, so no input reaches an output combinationally.
    assign ld_ready = (state != RUN);
    assign busy     = (state == RUN);
    assign load     = ld_valid & ld_ready;
    assign inc      = (state == RUN) & cnt_en;

    pcle_next #(.WIDTH(WIDTH)) u_next (
        .count      (count),
        .ld_data    (ld_data),
        .load       (load),
        .inc        (inc),
        .next_count (next_count),
        .wrap       (wrap)
    );

    always_comb begin
        state_next = state;
        if (load) begin
            state_next = IDLE;
        end else if (start && state != RUN) begin
            state_next = RUN;
        end else if (wrap && TC_HALT) begin
            state_next = HALT;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            count <= '0;
            carry <= 1'b0;
            done  <= 1'b0;
        end else if (clr) begin
            state <= IDLE;
            count <= '0;
            carry <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            count <= next_count;
            carry <= wrap;
            done  <= wrap & TC_HALT;
        end
    end

endmodule

// File: tb/tb_pcle_seq.sv
// Directed self-checking bench for pcle_seq; a second instance covers TC_HALT=0.
module tb_pcle_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       clr = 1'b0;
    logic       ld_valid = 1'b0;
    logic [7:0] ld_data = 8'h00;
    logic       start = 1'b0;
    logic       cnt_en = 1'b0;

    logic       ld_ready, carry, busy, done;
    logic [7:0] count;
    logic       fr_ld_ready, fr_carry, fr_busy, fr_done;
    logic [7:0] fr_count;

    int checks = 0;
    int errors = 0;

    pcle_seq #(.WIDTH(8), .TC_HALT(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .ld_valid(ld_valid), .ld_ready(ld_ready),
        .ld_data(ld_data), .start(start), .cnt_en(cnt_en), .count(count),
        .carry(carry), .busy(busy), .done(done)
    );

    pcle_seq #(.WIDTH(8), .TC_HALT(1'b0)) dut_fr (
        .clk(clk), .rst_n(rst_n), .clr(clr), .ld_valid(ld_valid), .ld_ready(fr_ld_ready),
        .ld_data(ld_data), .start(start), .cnt_en(cnt_en), .count(fr_count),
        .carry(fr_carry), .busy(fr_busy), .done(fr_done)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle; outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check the halting instance's outputs against hand-computed values.
    task automatic expect_main(input string name, input logic [7:0] e_count, input logic e_carry,
                               input logic e_done, input logic e_busy, input logic e_ready);
        checks++;
        if (count !== e_count || carry !== e_carry || done !== e_done ||
            busy !== e_busy || ld_ready !== e_ready) begin
            errors++;
            $display("FAIL %s: got count=%h carry=%b done=%b busy=%b ld_ready=%b, expected count=%h carry=%b done=%b busy=%b ld_ready=%b",
                     name, count, carry, done, busy, ld_ready, e_count, e_carry, e_done, e_busy, e_ready);
        end
    endtask

    task automatic do_load(input logic [7:0] v);
        ld_valid = 1'b1; ld_data = v;
        tick();
        ld_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        expect_main("reset_async", 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        rst_n = 1'b1;
        tick();
        expect_main("reset_release", 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_load();
        do_load(8'h3C);
        expect_main("load_3c", 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1);
        cnt_en = 1'b1;
        tick();
        expect_main("idle_hold", 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1);
        cnt_en = 1'b0;
        ld_valid = 1'b1; ld_data = 8'h42; start = 1'b1;
        tick();
        ld_valid = 1'b0; start = 1'b0;
        expect_main("load_beats_start", 8'h42, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_wrap_halt();
        do_load(8'hFD);
        do_start();
        expect_main("start_run", 8'hFD, 1'b0, 1'b0, 1'b1, 1'b0);
        cnt_en = 1'b1;
        tick();
        expect_main("wrap_fe", 8'hFE, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        expect_main("wrap_ff", 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        expect_main("wrap_00", 8'h00, 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        expect_main("halt_hold", 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        expect_main("halt_restart", 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        expect_main("restart_count", 8'h01, 1'b0, 1'b0, 1'b1, 1'b0);
        cnt_en = 1'b0;
        do_clr();
    endtask

    task automatic test_ignore_in_run();
        do_load(8'h10);
        do_start();
        ld_valid = 1'b1; ld_data = 8'hAA; start = 1'b1;
        cnt_en = 1'b1;
        tick();
        expect_main("run_en1", 8'h11, 1'b0, 1'b0, 1'b1, 1'b0);
        cnt_en = 1'b0;
        tick();
        expect_main("run_en0", 8'h11, 1'b0, 1'b0, 1'b1, 1'b0);
        cnt_en = 1'b1;
        tick();
        expect_main("run_en1b", 8'h12, 1'b0, 1'b0, 1'b1, 1'b0);
        ld_valid = 1'b0; start = 1'b0; cnt_en = 1'b0;
    endtask

    task automatic test_clr();
        do_clr();
        do_load(8'h55);
        do_start();
        clr = 1'b1; ld_valid = 1'b1; ld_data = 8'hAA; cnt_en = 1'b1;
        tick();
        clr = 1'b0; ld_valid = 1'b0; cnt_en = 1'b0;
        expect_main("clr_over_load", 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        do_load(8'hFF);
        do_start();
        clr = 1'b1; cnt_en = 1'b1;
        tick();
        clr = 1'b0; cnt_en = 1'b0;
        expect_main("clr_at_ff", 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_free_run();
        do_load(8'hFF);
        do_start();
        cnt_en = 1'b1;
        tick();
        checks++;
        if (fr_count !== 8'h00 || fr_carry !== 1'b1 || fr_busy !== 1'b1 || fr_done !== 1'b0) begin
            errors++;
            $display("FAIL free_wrap: got count=%h carry=%b busy=%b done=%b, expected count=00 carry=1 busy=1 done=0",
                     fr_count, fr_carry, fr_busy, fr_done);
        end
        tick();
        checks++;
        if (fr_count !== 8'h01 || fr_carry !== 1'b0 || fr_busy !== 1'b1 || fr_done !== 1'b0 || fr_ld_ready !== 1'b0) begin
            errors++;
            $display("FAIL free_next: got count=%h carry=%b busy=%b done=%b ld_ready=%b, expected count=01 carry=0 busy=1 done=0 ld_ready=0",
                     fr_count, fr_carry, fr_busy, fr_done, fr_ld_ready);
        end
        cnt_en = 1'b0;
        do_clr();
    endtask

    task automatic test_reset_mid_run();
        do_load(8'h80);
        do_start();
        expect_main("pre_reset_run", 8'h80, 1'b0, 1'b0, 1'b1, 1'b0);
        cnt_en = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        expect_main("reset_mid_run", 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        rst_n = 1'b1;
        tick();
        expect_main("post_reset_idle", 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        expect_main("post_reset_hold", 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        cnt_en = 1'b0;
    endtask

    initial begin
        fork
            begin
                test_reset();
                test_load();
                test_wrap_halt();
                test_ignore_in_run();
                test_clr();
                test_free_run();
                test_reset_mid_run();
            end
            begin
                #20000;
                $display("FAIL timeout: simulation exceeded time budget");
                $fatal(1, "timeout");
            end
        join_any
        disable fork;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
